// File: rtl/line_fill_server_if.sv
// Bundles the cache-side fill handshake and the memory-side word-read bus of line_fill_server.
// slave is the server's view, master is the view of the cache/memory environment driving it.
interface line_fill_server_if;
  logic [31:0]  addr_i;
  logic         rd_i;
  logic [255:0] data_o;
  logic         ack_o;
  logic         hw_page_fault_o;
  logic [31:0]  mem_addr_o;
  logic         mem_rd_o;
  logic [31:0]  mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  addr_i, rd_i, mem_data_i, mem_ack_i,
    output data_o, ack_o, hw_page_fault_o, mem_addr_o, mem_rd_o
  );

  modport master (
    output addr_i, rd_i, mem_data_i, mem_ack_i,
    input  data_o, ack_o, hw_page_fault_o, mem_addr_o, mem_rd_o
  );
endinterface

// File: rtl/line_fill_server.sv
// Fills a 32-byte cache line as eight gapped 32-bit word reads; lines at or above MEM_LIMIT fault.
// Optional per-word timeout is enabled by defining LINE_FILL_TIMEOUT_EN.
module line_fill_server #(
  parameter logic [31:0] MEM_LIMIT = 32'hFFFF_F000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  line_fill_server_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, GAP, RESP} state_e;

  state_e       state_q;
  logic [26:0]  base_q;
  logic [2:0]   idx_q;
  logic [255:0] line_q;
  logic         ack_q;
  logic         fault_q;
  logic         mem_rd_q;
  logic [31:0]  mem_addr_q;

  logic [31:0]  req_base_d;
  logic [2:0]   idx_d;
  logic         unused_addr_bits;

  assign req_base_d       = {bus.addr_i[31:5], 5'b0};
  assign idx_d            = idx_q + 3'd1;
  assign unused_addr_bits = ^bus.addr_i[4:0];

`ifdef LINE_FILL_TIMEOUT_EN
  logic [7:0] cnt_q;
`else
  localparam int unsigned timeout_unused = TIMEOUT;
`endif

  // NOTE: every register here is state, so only non-blocking assignments appear; the line
  // buffer is a plain register bank (not a RAM) and is reset with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      line_q     <= '0;
      ack_q      <= 1'b0;
      fault_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
`ifdef LINE_FILL_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rd_i) begin
            base_q <= req_base_d[31:5];
            idx_q  <= '0;
            if (req_base_d >= MEM_LIMIT) begin
              fault_q <= 1'b1;
              line_q  <= '0;
              ack_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              fault_q    <= 1'b0;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= req_base_d;
`ifdef LINE_FILL_TIMEOUT_EN
              cnt_q      <= '0;
`endif
              state_q    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.mem_ack_i) begin
            line_q[{idx_q, 5'b00000} +: 32] <= bus.mem_data_i;
            mem_rd_q <= 1'b0;
            if (idx_q == 3'd7) begin
              ack_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              idx_q      <= idx_d;
              mem_addr_q <= {base_q, idx_d, 2'b00};
              state_q    <= GAP;
            end
          end
`ifdef LINE_FILL_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT)) begin
            mem_rd_q <= 1'b0;
            fault_q  <= 1'b1;
            line_q   <= '0;
            ack_q    <= 1'b1;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        GAP: begin
          // The address was already advanced on the ack; only the request is re-raised here.
          mem_rd_q <= 1'b1;
`ifdef LINE_FILL_TIMEOUT_EN
          cnt_q    <= '0;
`endif
          state_q  <= FETCH;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_o          = line_q;
  assign bus.ack_o           = ack_q;
  assign bus.hw_page_fault_o = fault_q;
  assign bus.mem_addr_o      = mem_addr_q;
  assign bus.mem_rd_o        = mem_rd_q;

endmodule
